// File: rtl/lcd_msg_driver_pkg.sv
// Shared constants for the LCD message driver: HD44780 command bytes,
// main FSM state encoding and the two 16-character text tables.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_LOAD,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2,
    ST_IDLE
  } main_state_t;

  // Each row is 16 ASCII characters, first character in the top byte.
  localparam logic [127:0] ROM1 [4] = '{
    {"LISTO",     {11{8'h20}}},
    {"PROCESO 1", {7{8'h20}}},
    {"PROCESO 2", {7{8'h20}}},
    {"ERROR",     {11{8'h20}}}
  };

  localparam logic [127:0] ROM2 [4] = '{
    {16{8'h20}},
    {"VEL BAJA", {8{8'h20}}},
    {"VEL ALTA", {8{8'h20}}},
    {"PAUSA",    {11{8'h20}}}
  };

  // Character idx of a row; 15-idx equals ~idx for a 4-bit index.
  function automatic logic [7:0] rom_char(input logic [127:0] row, input logic [3:0] idx);
    logic [6:0] sh;
    sh = {~idx, 3'b000};
    return row[sh +: 8];
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_msg_driver_if.sv
// Display-side bundle: message codes from the controller FSM in, LCD
// header pins and status out.
interface lcd_msg_driver_if;
  logic [1:0] msg_code;
  logic [1:0] msg_sub;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic       ready;
  logic       busy;

  modport master (
    input  msg_code, msg_sub,
    output lcd_rs, lcd_rw, lcd_e, lcd_data, ready, busy
  );

  modport slave (
    output msg_code, msg_sub,
    input  lcd_rs, lcd_rw, lcd_e, lcd_data, ready, busy
  );
endinterface

// File: rtl/lcd_msg_driver_byte_writer.sv
// One LCD bus write: setup cycle, E high, E low, then a settle wait that is
// longer after the clear command. rs/data hold their value between writes.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int E_CYC        = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);

  localparam int MAX_W = (CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
  localparam int MAX_C = (MAX_W > E_CYC) ? MAX_W : E_CYC;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {BW_IDLE, BW_SETUP, BW_E_HI, BW_E_LO, BW_WAIT} bw_state_t;

  bw_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          e_q;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          busy_q;

  // Transfer phase sequencing with per-phase down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BW_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        BW_IDLE: begin
          if (start_i) begin
            state_q <= BW_SETUP;
            rs_q    <= rs_i;
            data_q  <= data_i;
            busy_q  <= 1'b1;
          end
        end
        BW_SETUP: begin
          state_q <= BW_E_HI;
          e_q     <= 1'b1;
          cnt_q   <= CW'(E_CYC - 1);
        end
        BW_E_HI: begin
          if (cnt_q == '0) begin
            state_q <= BW_E_LO;
            e_q     <= 1'b0;
            cnt_q   <= CW'(E_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BW_E_LO: begin
          if (cnt_q == '0) begin
            state_q <= BW_WAIT;
            cnt_q   <= (!rs_q && data_q == CMD_CLEAR) ? CW'(CLR_WAIT_CYC - 1)
                                                      : CW'(CMD_WAIT_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          if (cnt_q == '0) begin
            state_q <= BW_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign done_o     = (state_q == BW_WAIT) && (cnt_q == '0);
  assign busy_o     = busy_q;
  assign lcd_e_o    = e_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_msg_driver.sv
// Renders the controller's two message codes on a 16x2 HD44780 display.
// Optional build macro LCD_DIFF_UPDATE_EN: rewrite only the line whose code
// changed (the first refresh after init always writes both lines).
//
// state | meaning
// PWRUP | hold off after reset for the panel power-up time
// INIT  | send function set, display on, clear, entry mode
// LOAD  | latch codes, pick which lines to rewrite
// ADDR1 | set cursor to line 1
// LINE1 | write 16 characters of line 1
// ADDR2 | set cursor to line 2
// LINE2 | write 16 characters of line 2
// IDLE  | display current; watch for code changes
module lcd_msg_driver
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC  = 750000,
  parameter int E_CYC        = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  lcd_msg_driver_if.master  bus
);

  localparam int PW = $clog2(POWERUP_CYC + 1);

  main_state_t   state_q;
  logic [3:0]    idx_q;
  logic [PW-1:0] pwr_cnt_q;
  logic [1:0]    cur_code_q;
  logic [1:0]    cur_sub_q;
  logic          pending_q;
  logic          ready_q;
  logic          issued_q;
  logic          do_l2_q;

  logic          wb_start;
  logic          wb_rs;
  logic [7:0]    wb_data;
  logic          wb_busy;
  logic          wb_done;
  logic          send_st;
  logic          upd_line1;
  logic          upd_line2;

  // Byte to send in the current state; the writer latches it on start.
  always_comb begin
    wb_rs   = 1'b0;
    wb_data = 8'h00;
    send_st = 1'b1;
    case (state_q)
      ST_INIT:  wb_data = init_cmd(idx_q[1:0]);
      ST_ADDR1: wb_data = CMD_LINE1;
      ST_LINE1: begin
        wb_rs   = 1'b1;
        wb_data = rom_char(ROM1[cur_code_q], idx_q);
      end
      ST_ADDR2: wb_data = CMD_LINE2;
      ST_LINE2: begin
        wb_rs   = 1'b1;
        wb_data = rom_char(ROM2[cur_sub_q], idx_q);
      end
      default:  send_st = 1'b0;
    endcase
    wb_start = send_st && !issued_q;
  end

  // Line selection for the next refresh.
  always_comb begin
`ifdef LCD_DIFF_UPDATE_EN
    upd_line1 = pending_q || (bus.msg_code != cur_code_q);
    upd_line2 = pending_q || (bus.msg_sub != cur_sub_q);
`else
    upd_line1 = 1'b1;
    upd_line2 = 1'b1;
`endif
  end

  // Main sequencing FSM; one byte issued per send state step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_PWRUP;
      idx_q      <= 4'd0;
      pwr_cnt_q  <= '0;
      cur_code_q <= 2'd0;
      cur_sub_q  <= 2'd0;
      pending_q  <= 1'b0;
      ready_q    <= 1'b0;
      issued_q   <= 1'b0;
      do_l2_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_PWRUP: begin
          if (pwr_cnt_q == PW'(POWERUP_CYC - 1)) begin
            state_q   <= ST_INIT;
            pwr_cnt_q <= '0;
          end else begin
            pwr_cnt_q <= pwr_cnt_q + 1'b1;
          end
        end
        ST_LOAD: begin
          cur_code_q <= bus.msg_code;
          cur_sub_q  <= bus.msg_sub;
          pending_q  <= 1'b0;
          do_l2_q    <= upd_line2;
          idx_q      <= 4'd0;
          if (upd_line1) begin
            state_q <= ST_ADDR1;
          end else if (upd_line2) begin
            state_q <= ST_ADDR2;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (pending_q || bus.msg_code != cur_code_q || bus.msg_sub != cur_sub_q) begin
            state_q <= ST_LOAD;
            ready_q <= 1'b0;
          end
        end
        default: begin
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (wb_done) begin
            issued_q <= 1'b0;
            case (state_q)
              ST_INIT: begin
                if (idx_q == 4'd3) begin
                  state_q   <= ST_LOAD;
                  idx_q     <= 4'd0;
                  pending_q <= 1'b1;
                end else begin
                  idx_q <= idx_q + 4'd1;
                end
              end
              ST_ADDR1: state_q <= ST_LINE1;
              ST_LINE1: begin
                idx_q <= idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                  state_q <= do_l2_q ? ST_ADDR2 : ST_IDLE;
                  ready_q <= !do_l2_q;
                end
              end
              ST_ADDR2: state_q <= ST_LINE2;
              default: begin
                idx_q <= idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  lcd_byte_writer #(
    .E_CYC       (E_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_writer (
    .clk       (clk),
    .reset     (reset),
    .start_i   (wb_start),
    .rs_i      (wb_rs),
    .data_i    (wb_data),
    .busy_o    (wb_busy),
    .done_o    (wb_done),
    .lcd_e_o   (bus.lcd_e),
    .lcd_rs_o  (bus.lcd_rs),
    .lcd_data_o(bus.lcd_data)
  );

  assign bus.lcd_rw = 1'b0;
  assign bus.ready  = ready_q;
  assign bus.busy   = wb_busy;

endmodule

// File: tb/tb_lcd_msg_driver.sv
// Scoreboard bench for lcd_msg_driver: expected bus bytes are queued by the
// stimulus, and a monitor compares each byte on the rising edge of E.
module tb_lcd_msg_driver;

  localparam int P_PWR = 20;
  localparam int P_E   = 2;
  localparam int P_CMD = 4;
  localparam int P_CLR = 10;

`ifdef LCD_DIFF_UPDATE_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  localparam logic [127:0] S_SP    = {16{8'h20}};
  localparam logic [127:0] S_LISTO = {"LISTO", {11{8'h20}}};
  localparam logic [127:0] S_P1    = {"PROCESO 1", {7{8'h20}}};
  localparam logic [127:0] S_P2    = {"PROCESO 2", {7{8'h20}}};
  localparam logic [127:0] S_ERR   = {"ERROR", {11{8'h20}}};
  localparam logic [127:0] S_VA    = {"VEL ALTA", {8{8'h20}}};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_msg_driver_if bus();

  lcd_msg_driver #(
    .POWERUP_CYC (P_PWR),
    .E_CYC       (P_E),
    .CMD_WAIT_CYC(P_CMD),
    .CLR_WAIT_CYC(P_CLR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         cyc = 0;
  int         rises = 0;
  int         rise_cyc[$];
  logic [8:0] exp_q[$];
  logic [8:0] exp_b;
  logic       e_prev = 1'b0;
  int         n0;
  int         nw;
  bit         ready_ok;
  bit         busy_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_cmd(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic push_line(input logic [127:0] s);
    logic [127:0] r;
    r = s;
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, r[127-8*i -: 8]});
  endtask

  task automatic push_refresh(input logic [127:0] l1, input logic [127:0] l2,
                              input bit w1, input bit w2);
    if (w1) begin push_cmd(8'h80); push_line(l1); end
    if (w2) begin push_cmd(8'hC0); push_line(l2); end
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.ready && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, bus.ready, 1);
  endtask

  task automatic release_and_init(input logic [127:0] l1, input logic [127:0] l2);
    int c0;
    push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h01); push_cmd(8'h06);
    push_refresh(l1, l2, 1'b1, 1'b1);
    rise_cyc.delete();
    c0 = cyc;
    reset = 1'b0;
    wait_ready("init_ready", 3000);
    chk("init_rise_count", rise_cyc.size() >= 4, 1);
    if (rise_cyc.size() >= 4) begin
      chk("pwrup_latency", rise_cyc[0] - c0, 22);
      chk("gap_disp_on_to_clear", rise_cyc[2] - rise_cyc[1], 10);
      chk("gap_after_clear", rise_cyc[3] - rise_cyc[2], 16);
    end
    chk("init_queue_drained", exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every E rising edge consumes one expected {rs,data}.
  always @(negedge clk) begin
    if (bus.lcd_e && !e_prev) begin
      rises <= rises + 1;
      rise_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_byte: got rs=%0b data=0x%02h with nothing expected (cycle %0d)",
                 bus.lcd_rs, bus.lcd_data, cyc);
      end else begin
        exp_b = exp_q.pop_front();
        chk("lcd_byte", {bus.lcd_rs, bus.lcd_data}, exp_b);
      end
    end
    e_prev <= bus.lcd_e;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.msg_code = 2'd0;
    bus.msg_sub  = 2'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_lcd_e", bus.lcd_e, 0);
    chk("rst_lcd_rs", bus.lcd_rs, 0);
    chk("rst_lcd_data", bus.lcd_data, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_lcd_rw", bus.lcd_rw, 0);

    // Power-up, init and first full refresh with codes 0/0.
    release_and_init(S_LISTO, S_SP);

    // Line-1 code change from IDLE.
    push_refresh(S_ERR, S_SP, 1'b1, !DIFF);
    n0 = rises;
    bus.msg_code = 2'd3;
    @(posedge clk); #2;
    chk("ready_fall", bus.ready, 0);
    wait_ready("err_ready", 2000);
    chk("err_byte_count", rises - n0, DIFF ? 17 : 34);
    chk("err_queue_drained", exp_q.size(), 0);

    // Line-2 code change in the middle of a line-1 refresh.
    push_refresh(S_P1, S_SP, 1'b1, !DIFF);
    push_refresh(S_P1, S_VA, !DIFF, 1'b1);
    n0 = rises;
    bus.msg_code = 2'd1;
    nw = 0;
    while (rises < n0 + 3 && nw < 2000) begin
      @(posedge clk); #2;
      nw++;
    end
    chk("reached_line1", rises >= n0 + 3, 1);
    bus.msg_sub = 2'd2;
    wait_ready("ready_pulse", 2000);
    @(posedge clk); #2;
    chk("ready_pulse_width", bus.ready, 0);
    wait_ready("sub_ready", 2000);
    chk("sub_byte_count", rises - n0, DIFF ? 34 : 68);
    chk("sub_queue_drained", exp_q.size(), 0);

    // Reset while E is high aborts at once; init reruns.
    bus.msg_code = 2'd2;
    nw = 0;
    while (!bus.lcd_e && nw < 2000) begin
      @(posedge clk); #2;
      nw++;
    end
    chk("saw_e_high", bus.lcd_e, 1);
    reset = 1'b1;
    #1;
    chk("abort_lcd_e", bus.lcd_e, 0);
    chk("abort_lcd_data", bus.lcd_data, 0);
    chk("abort_ready", bus.ready, 0);
    chk("abort_busy", bus.busy, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    release_and_init(S_P2, S_VA);

    // Quiet IDLE: no bus activity with steady codes.
    n0 = rises;
    ready_ok = 1'b1;
    busy_ok  = 1'b1;
    repeat (1000) begin
      @(posedge clk); #2;
      if (!bus.ready) ready_ok = 1'b0;
      if (bus.busy) busy_ok = 1'b0;
    end
    chk("idle_no_e", rises - n0, 0);
    chk("idle_ready_held", ready_ok, 1);
    chk("idle_busy_low", busy_ok, 1);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
